// File: rtl/eth_rx_mac_filter_pkg.sv
// Shared constants, state encoding and address-match helper for the Ethernet RX MAC filter.
package eth_rx_mac_filter_pkg;
  localparam int          HDR_LEN   = 6;
  localparam logic [2:0]  HDR_LAST  = 3'(HDR_LEN - 1);
  localparam logic [47:0] BCAST_MAC = 48'hFFFF_FFFF_FFFF;

  typedef enum logic [2:0] {ST_IDLE, ST_HDR, ST_PASS, ST_DROP, ST_FLUSH} state_e;
  typedef enum logic [1:0] {DL_HOLD, DL_SHIFT, DL_POP, DL_CLEAR} dl_op_e;

  // Group bit is the LSB of the first DA byte on the wire.
  function automatic logic da_match(input logic [47:0] da, input logic [47:0] mac,
                                    input logic promisc, input logic bcast, input logic mcast);
    return promisc | (da == mac) | (bcast & (da == BCAST_MAC)) | (mcast & da[40]);
  endfunction
endpackage

// File: rtl/eth_byte_delay_line.sv
// Six-entry byte delay line; entry 0 is newest, entry HDR_LEN-1 the oldest byte.
module eth_byte_delay_line
  import eth_rx_mac_filter_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  dl_op_e                  op_i,
  input  logic [7:0]              din_i,
  output logic [HDR_LEN-1:0][7:0] taps_o
);
  logic [HDR_LEN-1:0][7:0] line_q, line_d;

  always_comb begin
    line_d = line_q;
    unique case (op_i)
      DL_SHIFT: line_d = {line_q[HDR_LEN-2:0], din_i};
      DL_POP:   line_d = {line_q[HDR_LEN-2:0], 8'h00};
      DL_CLEAR: line_d = '0;
      default:  ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) line_q <= '0;
    else     line_q <= line_d;
  end

  assign taps_o = line_q;
endmodule

// File: rtl/eth_rx_mac_filter.sv
// Receive-side destination-address filter: buffers the 6-byte DA, decides pass/drop,
// then streams the frame out delayed by six beats and drains the tail in FLUSH.
module eth_rx_mac_filter
  import eth_rx_mac_filter_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  s_axis_tdata_i,
  input  logic        s_axis_tvalid_i,
  input  logic        s_axis_tlast_i,
  input  logic        s_axis_tuser_i,
  output logic [7:0]  m_axis_tdata_o,
  output logic        m_axis_tvalid_o,
  output logic        m_axis_tlast_o,
  output logic        m_axis_tuser_o,
  input  logic [47:0] local_mac_i,
  input  logic        promisc_en_i,
  input  logic        bcast_en_i,
  input  logic        mcast_en_i,
  output logic        frame_pass_o,
  output logic        frame_drop_o,
  output logic        overrun_o
);
  state_e                  state_q, state_d;
  logic [2:0]              cnt_q, cnt_d;
  logic                    tuser_q, tuser_d, ovr_q, ovr_d;
  logic [7:0]              tdata_q, tdata_d;
  logic                    tvalid_q, tvalid_d, tlast_q, tlast_d, mtuser_q, mtuser_d;
  logic                    pass_q, pass_d, drop_q, drop_d, overrun_q, overrun_d;
  dl_op_e                  dl_op;
  logic [HDR_LEN-1:0][7:0] taps;
  logic                    hit;

  eth_byte_delay_line u_dline (
    .clk    (clk),
    .rst    (rst),
    .op_i   (dl_op),
    .din_i  (s_axis_tdata_i),
    .taps_o (taps)
  );

  // Only meaningful on the 6th header byte, which completes the DA in flight.
  assign hit = da_match({taps[HDR_LEN-2:0], s_axis_tdata_i}, local_mac_i,
                        promisc_en_i, bcast_en_i, mcast_en_i);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    tuser_d   = tuser_q;
    ovr_d     = ovr_q;
    dl_op     = DL_HOLD;
    tdata_d   = '0;
    tvalid_d  = 1'b0;
    tlast_d   = 1'b0;
    mtuser_d  = 1'b0;
    pass_d    = 1'b0;
    drop_d    = 1'b0;
    overrun_d = 1'b0;
    unique case (state_q)
      ST_IDLE: if (s_axis_tvalid_i) begin
        if (s_axis_tlast_i) begin
          drop_d = 1'b1;
          dl_op  = DL_CLEAR;
        end else begin
          dl_op   = DL_SHIFT;
          cnt_d   = 3'd1;
          state_d = ST_HDR;
        end
      end
      ST_HDR: if (s_axis_tvalid_i) begin
        cnt_d = cnt_q + 3'd1;
        dl_op = DL_SHIFT;
        if (cnt_q == HDR_LAST) begin
          cnt_d = '0;
          if (hit) begin
            pass_d  = 1'b1;
            tuser_d = s_axis_tuser_i;
            ovr_d   = 1'b0;
            state_d = s_axis_tlast_i ? ST_FLUSH : ST_PASS;
          end else begin
            drop_d  = 1'b1;
            dl_op   = DL_CLEAR;
            state_d = s_axis_tlast_i ? ST_IDLE : ST_DROP;
          end
        end else if (s_axis_tlast_i) begin
          drop_d  = 1'b1;
          dl_op   = DL_CLEAR;
          cnt_d   = '0;
          state_d = ST_IDLE;
        end
      end
      ST_PASS: if (s_axis_tvalid_i) begin
        dl_op    = DL_SHIFT;
        tvalid_d = 1'b1;
        tdata_d  = taps[HDR_LEN-1];
        if (s_axis_tlast_i) begin
          tuser_d = s_axis_tuser_i;
          ovr_d   = 1'b0;
          cnt_d   = '0;
          state_d = ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        dl_op    = DL_POP;
        tvalid_d = 1'b1;
        tdata_d  = taps[HDR_LEN-1];
        // Input arriving while draining has nowhere to go; its frame is discarded.
        if (s_axis_tvalid_i) begin
          overrun_d = 1'b1;
          ovr_d     = 1'b1;
        end
        if (cnt_q == HDR_LAST) begin
          tlast_d  = 1'b1;
          mtuser_d = tuser_q;
          cnt_d    = '0;
          state_d  = (ovr_q | s_axis_tvalid_i) ? ST_DROP : ST_IDLE;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      ST_DROP: if (s_axis_tvalid_i && s_axis_tlast_i) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      tuser_q   <= 1'b0;
      ovr_q     <= 1'b0;
      tdata_q   <= '0;
      tvalid_q  <= 1'b0;
      tlast_q   <= 1'b0;
      mtuser_q  <= 1'b0;
      pass_q    <= 1'b0;
      drop_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      tuser_q   <= tuser_d;
      ovr_q     <= ovr_d;
      tdata_q   <= tdata_d;
      tvalid_q  <= tvalid_d;
      tlast_q   <= tlast_d;
      mtuser_q  <= mtuser_d;
      pass_q    <= pass_d;
      drop_q    <= drop_d;
      overrun_q <= overrun_d;
    end
  end

  assign m_axis_tdata_o  = tdata_q;
  assign m_axis_tvalid_o = tvalid_q;
  assign m_axis_tlast_o  = tlast_q;
  assign m_axis_tuser_o  = mtuser_q;
  assign frame_pass_o    = pass_q;
  assign frame_drop_o    = drop_q;
  assign overrun_o       = overrun_q;
endmodule

// File: tb/tb_eth_rx_mac_filter.sv
// Bench for eth_rx_mac_filter: table of directed frames, hand-built corner sequences,
// then random frames scored against a frame-level reference model.
module tb_eth_rx_mac_filter;
  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  s_tdata;
  logic        s_tvalid, s_tlast, s_tuser;
  logic [7:0]  m_tdata;
  logic        m_tvalid, m_tlast, m_tuser;
  logic [47:0] local_mac;
  logic        promisc, bcast, mcast;
  logic        f_pass, f_drop, f_ovr;

  localparam logic [47:0] MY_MAC = 48'h02_00_00_00_00_01;
  localparam logic [47:0] BC_MAC = 48'hFF_FF_FF_FF_FF_FF;
  localparam logic [47:0] MC_MAC = 48'h01_00_5E_00_00_01;

  always #5 clk = ~clk;

  eth_rx_mac_filter dut (
    .clk(clk), .rst(rst),
    .s_axis_tdata_i(s_tdata), .s_axis_tvalid_i(s_tvalid),
    .s_axis_tlast_i(s_tlast), .s_axis_tuser_i(s_tuser),
    .m_axis_tdata_o(m_tdata), .m_axis_tvalid_o(m_tvalid),
    .m_axis_tlast_o(m_tlast), .m_axis_tuser_o(m_tuser),
    .local_mac_i(local_mac), .promisc_en_i(promisc), .bcast_en_i(bcast), .mcast_en_i(mcast),
    .frame_pass_o(f_pass), .frame_drop_o(f_drop), .overrun_o(f_ovr)
  );

  typedef struct {logic [7:0] d; logic l; logic u; int cyc;} ob_t;
  typedef struct {
    logic [47:0] da; int len; logic p, b, m; int gap; logic tu; int exp_pass;
  } vec_t;

  ob_t        out_q[$];
  logic [7:0] sent_q[$];
  int cyc = 0, pass_cnt = 0, drop_cnt = 0, ovr_cnt = 0, stray_user = 0;
  int total = 0, bad = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) if (!rst) begin
    if (m_tvalid) out_q.push_back('{m_tdata, m_tlast, m_tuser, cyc});
    if (m_tuser && !(m_tvalid && m_tlast)) stray_user++;
    if (f_pass) pass_cnt++;
    if (f_drop) drop_cnt++;
    if (f_ovr)  ovr_cnt++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end

  task automatic chk(input string nm, input longint act, input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic beat(input logic [7:0] d, input logic l, input logic u);
    s_tdata = d; s_tvalid = 1'b1; s_tlast = l; s_tuser = u;
    @(posedge clk); #1;
    s_tdata = '0; s_tvalid = 1'b0; s_tlast = 1'b0; s_tuser = 1'b0;
  endtask

  // gap: 0 back-to-back, 1 one idle between beats (MII), 2 random 0..2 idles
  task automatic send_frame(input logic [47:0] da, input int len, input logic tu, input int gap);
    logic [7:0] b;
    sent_q.delete();
    for (int i = 0; i < len; i++) begin
      b = (i < 6) ? da[47-8*i -: 8] : 8'($urandom);
      sent_q.push_back(b);
      beat(b, i == len-1, (i == len-1) ? tu : 1'b0);
      if (i != len-1) begin
        if (gap == 1) idle(1);
        else if (gap == 2) idle($urandom_range(0, 2));
      end
    end
  endtask

  // Reference: a frame passes iff it carries a whole DA and the DA satisfies the enables.
  function automatic int model_pass(input logic [47:0] da, input int len,
                                    input logic p, input logic b, input logic m);
    if (len < 6) return 0;
    return (p || da == MY_MAC || (b && da == BC_MAC) || (m && da[40])) ? 1 : 0;
  endfunction

  task automatic run_frame(input string tag, input vec_t v);
    int p0, d0, errs, exp_len;
    promisc = v.p; bcast = v.b; mcast = v.m;
    out_q.delete();
    p0 = pass_cnt; d0 = drop_cnt;
    send_frame(v.da, v.len, v.tu, v.gap);
    idle(12);
    exp_len = v.exp_pass ? v.len : 0;
    chk({tag, " pass"}, pass_cnt - p0, v.exp_pass);
    chk({tag, " drop"}, drop_cnt - d0, v.exp_pass ? 0 : 1);
    chk({tag, " out_len"}, out_q.size(), exp_len);
    if (v.exp_pass != 0 && out_q.size() == v.len) begin
      errs = 0;
      for (int i = 0; i < v.len; i++) begin
        if (out_q[i].d !== sent_q[i]) errs++;
        if (out_q[i].l !== (i == v.len-1)) errs++;
        if (out_q[i].u !== ((i == v.len-1) ? v.tu : 1'b0)) errs++;
      end
      chk({tag, " data/tlast/tuser errs"}, errs, 0);
    end
  endtask

  vec_t tbl[10];

  initial begin
    int p0, d0, o0;
    vec_t v;
    rst = 1'b1; s_tdata = '0; s_tvalid = 1'b0; s_tlast = 1'b0; s_tuser = 1'b0;
    local_mac = MY_MAC; promisc = 1'b0; bcast = 1'b0; mcast = 1'b0;

    tbl[0] = '{MY_MAC,              64, 0, 0, 0, 0, 1'b0, 1};
    tbl[1] = '{BC_MAC,              20, 0, 0, 0, 0, 1'b0, 0};
    tbl[2] = '{BC_MAC,              20, 0, 1, 0, 0, 1'b0, 1};
    tbl[3] = '{MC_MAC,              30, 0, 0, 1, 1, 1'b1, 1};
    tbl[4] = '{MC_MAC,              30, 0, 0, 0, 1, 1'b0, 0};
    tbl[5] = '{48'h00_11_22_33_44_55, 7, 1, 0, 0, 2, 1'b1, 1};
    tbl[6] = '{48'h00_11_22_33_44_55, 7, 0, 1, 1, 0, 1'b0, 0};
    tbl[7] = '{MY_MAC,               6, 0, 0, 0, 1, 1'b1, 1};
    tbl[8] = '{48'h02_00_00_00_00_03, 10, 0, 0, 0, 0, 1'b0, 0};
    tbl[9] = '{48'h02_11_22_33_44_55, 10, 0, 0, 1, 0, 1'b0, 0};

    idle(3);
    chk("reset outputs", {m_tdata, m_tvalid, m_tlast, m_tuser, f_pass, f_drop, f_ovr}, 0);
    rst = 1'b0;
    idle(2);

    for (int i = 0; i < 10; i++) run_frame($sformatf("vec%0d", i), tbl[i]);

    // Runt then a 6-byte frame that is drained entirely by FLUSH.
    promisc = 1'b0; bcast = 1'b0; mcast = 1'b0;
    out_q.delete(); d0 = drop_cnt; p0 = pass_cnt;
    send_frame(MY_MAC, 4, 1'b0, 0);
    idle(8);
    chk("runt drop", drop_cnt - d0, 1);
    chk("runt no output", out_q.size(), 0);
    send_frame(MY_MAC, 6, 1'b1, 0);
    idle(12);
    chk("six-byte pass", pass_cnt - p0, 1);
    chk("six-byte out_len", out_q.size(), 6);
    if (out_q.size() == 6) begin
      chk("six-byte consecutive", out_q[5].cyc - out_q[0].cyc, 5);
      chk("six-byte last tlast/tuser", {out_q[5].l, out_q[5].u}, 2'b11);
      chk("six-byte first byte", out_q[0].d, 8'h02);
    end

    // Single-beat frame ends in IDLE.
    d0 = drop_cnt;
    send_frame(MY_MAC, 1, 1'b0, 0);
    idle(4);
    chk("one-byte drop", drop_cnt - d0, 1);

    // Second frame starts while the first is still draining.
    out_q.delete(); p0 = pass_cnt; o0 = ovr_cnt;
    send_frame(MY_MAC, 10, 1'b0, 0);
    idle(1);
    send_frame(MY_MAC, 10, 1'b0, 0);
    idle(12);
    chk("overrun pulsed", (ovr_cnt - o0) > 0, 1);
    chk("overrun one pass", pass_cnt - p0, 1);
    chk("overrun out_len", out_q.size(), 10);
    if (out_q.size() == 10) chk("overrun first tlast", out_q[9].l, 1'b1);
    v = '{MY_MAC, 9, 0, 0, 0, 0, 1'b0, 1};
    run_frame("after overrun", v);

    // Reset in the middle of a passing frame.
    out_q.delete();
    for (int i = 0; i < 20; i++) beat((i < 6) ? MY_MAC[47-8*i -: 8] : 8'(i), 1'b0, 1'b0);
    chk("pre-reset tvalid", m_tvalid, 1'b1);
    rst = 1'b1;
    #1;
    chk("async reset outputs", {m_tdata, m_tvalid, m_tlast, m_tuser}, 0);
    idle(2);
    rst = 1'b0;
    idle(1);
    chk("truncated no tlast", (out_q.size() > 0) ? out_q[out_q.size()-1].l : 1'b0, 1'b0);
    v = '{MY_MAC, 12, 0, 0, 0, 2, 1'b1, 1};
    run_frame("after reset", v);

    // Random frames vs reference model.
    for (int k = 0; k < 30; k++) begin
      case ($urandom_range(0, 3))
        0: v.da = MY_MAC;
        1: v.da = BC_MAC;
        2: v.da = {8'($urandom) | 8'h01, 40'($urandom) ^ {8'($urandom), 32'($urandom)}};
        default: v.da = {8'($urandom), 8'($urandom), 32'($urandom)};
      endcase
      v.len = $urandom_range(1, 24);
      v.p = ($urandom_range(0, 7) == 0);
      v.b = 1'($urandom);
      v.m = 1'($urandom);
      v.gap = $urandom_range(0, 2);
      v.tu = 1'($urandom);
      v.exp_pass = model_pass(v.da, v.len, v.p, v.b, v.m);
      run_frame($sformatf("rand%0d", k), v);
    end

    chk("tuser only on tlast", stray_user, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
